// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit.
//   - opcode codes for the low three opcode bits
//   - FSM state encoding
//   - helper that marks the opcodes that run a memory transfer in EXEC
package cu_pkg;

    localparam logic [2:0] OP_R   = 3'd0;
    localparam logic [2:0] OP_MFI = 3'd1;
    localparam logic [2:0] OP_MW  = 3'd2;
    localparam logic [2:0] OP_MR  = 3'd3;
    localparam logic [2:0] OP_J   = 3'd4;
    localparam logic [2:0] OP_JCE = 3'd5;
    localparam logic [2:0] OP_MB  = 3'd6;
    localparam logic [2:0] OP_JCN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_MW) || (op == OP_MR);
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Memory-wait timer for the control unit.
//   clk, rst_n : clock, async active-low reset
//   clear      : force the count to 0 (any cycle not waiting on mem_ack)
//   tick       : one more cycle spent waiting without mem_ack
//   expired    : count has reached WAIT_MAX; constant 0 when WAIT_MAX = 0
module cu_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    generate
        if (WAIT_MAX == 0) begin : g_off
            logic unused_timer_inputs;
            assign unused_timer_inputs = clk ^ rst_n ^ clear ^ tick;
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(WAIT_MAX + 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Saturates at WAIT_MAX so a stalled clear can never wrap the count.
            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (tick && (cnt_q != CW'(WAIT_MAX))) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = (cnt_q == CW'(WAIT_MAX));
        end
    endgenerate

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 8-bit processor: sequences FETCH/DECODE/EXEC,
// handshakes with instruction/data memory and the I/O port, resolves conditional
// jumps and traps illegal opcodes.
//   Inputs : clk, rst_n, en, instr_i[INSTR_W], mem_ack, eq_flag,
//            io_in_valid, io_out_ready
//   Outputs: mem_req, mem_we, addr_sel, rm, wr, sin, sout, j, jc, neq,
//            pc_inc, pc_load, ir_load, busy, illegal (sticky), timeout (sticky)
//
// state  | meaning
// IDLE   | stopped, waiting for en
// FETCH  | read instruction at PC; on mem_ack load IR and bump PC
// DECODE | latch opcode, trap illegal codes
// EXEC   | run the opcode, possibly waiting on I/O or memory handshake
// WB     | write back the word read by MR
// HALT   | trapped (illegal opcode or memory timeout); only reset leaves
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int INSTR_W  = 8,
    parameter int OPCODE_W = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               mem_ack,
    input  logic               eq_flag,
    input  logic               io_in_valid,
    input  logic               io_out_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               rm,
    output logic               wr,
    output logic               sin,
    output logic               sout,
    output logic               j,
    output logic               jc,
    output logic               neq,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               ir_load,
    output logic               busy,
    output logic               illegal,
    output logic               timeout
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;

    logic [OPCODE_W-1:0] op_field;
    logic                op_field_illegal;
    logic [2:0]          op_low;
    logic                in_mem_wait;
    logic                wait_expired;
    state_e              state_after;

    assign op_field = instr_i[INSTR_W-1 -: OPCODE_W];
    assign op_low   = op_q[2:0];

    // Operand bits of the instruction are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[INSTR_W-OPCODE_W-1:0];

    // Only codes 0..7 exist; any set bit above bit 2 is an illegal opcode.
    generate
        if (OPCODE_W > 3) begin : g_wide_op
            assign op_field_illegal = |op_field[OPCODE_W-1:3];
        end else begin : g_narrow_op
            assign op_field_illegal = 1'b0;
        end
    endgenerate

    assign in_mem_wait = (state_q == ST_FETCH) ||
                         ((state_q == ST_EXEC) && is_mem_op(op_low));

    // The count restarts whenever we are not waiting, so every entry into a
    // request state begins at zero.
    cu_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_mem_wait || mem_ack),
        .tick    (in_mem_wait && !mem_ack),
        .expired (wait_expired)
    );

    assign state_after = en ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // An ack in the expiry cycle still completes the transfer.
                if (mem_ack) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                op_d = op_field;
                if (op_field_illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_low)
                    OP_R:   if (io_out_ready) state_d = state_after;
                    OP_MFI: if (io_in_valid)  state_d = state_after;
                    OP_MW, OP_MR: begin
                        if (mem_ack) begin
                            state_d = (op_low == OP_MR) ? ST_WB : state_after;
                        end else if (wait_expired) begin
                            state_d   = ST_HALT;
                            timeout_d = 1'b1;
                        end
                    end
                    default: state_d = state_after;
                endcase
            end
            ST_WB:   state_d = state_after;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        rm       = 1'b0;
        wr       = 1'b0;
        sin      = 1'b0;
        sout     = 1'b0;
        j        = 1'b0;
        jc       = 1'b0;
        neq      = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ir_load  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
                pc_inc  = mem_ack;
            end
            ST_EXEC: begin
                case (op_low)
                    OP_R:   sout = 1'b1;
                    OP_MFI: begin
                        sin = 1'b1;
                        wr  = io_in_valid;
                    end
                    OP_MW: begin
                        mem_req  = 1'b1;
                        mem_we   = 1'b1;
                        addr_sel = 1'b1;
                    end
                    OP_MR: begin
                        mem_req  = 1'b1;
                        rm       = 1'b1;
                        addr_sel = 1'b1;
                    end
                    OP_J: begin
                        j       = 1'b1;
                        pc_load = 1'b1;
                    end
                    OP_JCE: begin
                        jc      = 1'b1;
                        pc_load = eq_flag;
                    end
                    OP_MB:  wr = 1'b1;
                    OP_JCN: begin
                        jc      = 1'b1;
                        neq     = 1'b1;
                        pc_load = ~eq_flag;
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                rm = 1'b1;
                wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic mem_req, mem_we, addr_sel, rm, wr, sin, sout, j, jc, neq;
        logic pc_inc, pc_load, ir_load, busy, illegal, timeout;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mem_ack, eq_flag, io_in_valid, io_out_ready;
    logic [7:0] instr_i;
    logic       en_1, ack_1;
    logic [7:0] instr_1;

    logic mem_req, mem_we, addr_sel, rm, wr, sin, sout, j, jc, neq;
    logic pc_inc, pc_load, ir_load, busy, illegal, timeout;
    logic mem_req_1, mem_we_1, addr_sel_1, rm_1, wr_1, sin_1, sout_1, j_1, jc_1, neq_1;
    logic pc_inc_1, pc_load_1, ir_load_1, busy_1, illegal_1, timeout_1;

    outs_t act0, act1;
    assign act0 = {mem_req, mem_we, addr_sel, rm, wr, sin, sout, j, jc, neq,
                   pc_inc, pc_load, ir_load, busy, illegal, timeout};
    assign act1 = {mem_req_1, mem_we_1, addr_sel_1, rm_1, wr_1, sin_1, sout_1, j_1, jc_1, neq_1,
                   pc_inc_1, pc_load_1, ir_load_1, busy_1, illegal_1, timeout_1};

    always #5 clk = ~clk;

    multicycle_control_unit #(.INSTR_W(8), .OPCODE_W(3), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .instr_i(instr_i), .mem_ack(mem_ack),
        .eq_flag(eq_flag), .io_in_valid(io_in_valid), .io_out_ready(io_out_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .rm(rm), .wr(wr),
        .sin(sin), .sout(sout), .j(j), .jc(jc), .neq(neq), .pc_inc(pc_inc),
        .pc_load(pc_load), .ir_load(ir_load), .busy(busy), .illegal(illegal),
        .timeout(timeout));

    multicycle_control_unit #(.INSTR_W(8), .OPCODE_W(4), .WAIT_MAX(WAIT_MAX)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .en(en_1), .instr_i(instr_1), .mem_ack(ack_1),
        .eq_flag(eq_flag), .io_in_valid(io_in_valid), .io_out_ready(io_out_ready),
        .mem_req(mem_req_1), .mem_we(mem_we_1), .addr_sel(addr_sel_1), .rm(rm_1), .wr(wr_1),
        .sin(sin_1), .sout(sout_1), .j(j_1), .jc(jc_1), .neq(neq_1), .pc_inc(pc_inc_1),
        .pc_load(pc_load_1), .ir_load(ir_load_1), .busy(busy_1), .illegal(illegal_1),
        .timeout(timeout_1));

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what phase of the instruction life cycle we are in,
    // which instruction is running and how long memory has kept us waiting.
    typedef enum {M_IDLE, M_FETCH, M_DECODE, M_EXEC, M_WB, M_HALT} mphase_e;
    mphase_e m_ph;
    int      m_op, m_wait;
    logic    m_ill, m_to;

    function automatic bit waits_on_mem(input int op);
        return (op == 2) || (op == 3);
    endfunction

    function automatic bit exec_finishes(input int op, input logic ack, input logic iv, input logic ordy);
        if (op == 0) return ordy;
        if (op == 1) return iv;
        if (waits_on_mem(op)) return ack;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= M_IDLE; m_op <= 0; m_wait <= 0; m_ill <= 1'b0; m_to <= 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: if (en) begin m_ph <= M_FETCH; m_wait <= 0; end
                M_FETCH: begin
                    if (mem_ack) m_ph <= M_DECODE;
                    else if (m_wait >= WAIT_MAX) begin m_ph <= M_HALT; m_to <= 1'b1; end
                    else m_wait <= m_wait + 1;
                end
                M_DECODE: begin
                    m_op <= int'(instr_i) / 32;
                    m_wait <= 0;
                    m_ph <= M_EXEC;
                end
                M_EXEC: begin
                    if (exec_finishes(m_op, mem_ack, io_in_valid, io_out_ready)) begin
                        m_wait <= 0;
                        if (m_op == 3) m_ph <= M_WB;
                        else if (en)   m_ph <= M_FETCH;
                        else           m_ph <= M_IDLE;
                    end else if (waits_on_mem(m_op)) begin
                        if (m_wait >= WAIT_MAX) begin m_ph <= M_HALT; m_to <= 1'b1; end
                        else m_wait <= m_wait + 1;
                    end
                end
                M_WB: begin
                    m_wait <= 0;
                    if (en) m_ph <= M_FETCH; else m_ph <= M_IDLE;
                end
                default: ;
            endcase
        end
    end

    function automatic outs_t model_out();
        outs_t o;
        o = '0;
        o.illegal = m_ill;
        o.timeout = m_to;
        o.busy    = (m_ph != M_IDLE) && (m_ph != M_HALT);
        if (m_ph == M_FETCH) begin
            o.mem_req = 1'b1; o.ir_load = mem_ack; o.pc_inc = mem_ack;
        end else if (m_ph == M_WB) begin
            o.rm = 1'b1; o.wr = 1'b1;
        end else if (m_ph == M_EXEC) begin
            case (m_op)
                0: o.sout = 1'b1;
                1: begin o.sin = 1'b1; o.wr = io_in_valid; end
                2: begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.addr_sel = 1'b1; end
                3: begin o.mem_req = 1'b1; o.rm = 1'b1; o.addr_sel = 1'b1; end
                4: begin o.j = 1'b1; o.pc_load = 1'b1; end
                5: begin o.jc = 1'b1; o.pc_load = eq_flag; end
                6: o.wr = 1'b1;
                default: begin o.jc = 1'b1; o.neq = 1'b1; o.pc_load = !eq_flag; end
            endcase
        end
        return o;
    endfunction

    logic w4_strobe_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chkv("reset_outputs_zero", act0, '0);
            chkv("reset_outputs_zero_w4", act1, '0);
        end else begin
            chkv("model_cycle", act0, model_out());
            chk1("pc_inc_pc_load_exclusive", pc_inc & pc_load, 1'b0);
        end
        if (wr_1 || pc_load_1) w4_strobe_seen = 1'b1;
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Enter with DUT in FETCH just after a clock edge; leave at the start of EXEC.
    task automatic fetch(input logic [7:0] ins);
        instr_i = ins; mem_ack = 1'b1;
        smp();
        chk1("fetch_ir_load", ir_load, 1'b1);
        chk1("fetch_addr_sel", addr_sel, 1'b0);
        nxt();
        mem_ack = 1'b0;
        smp();
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mem_ack = 1'b0; eq_flag = 1'b0;
        io_in_valid = 1'b0; io_out_ready = 1'b0; instr_i = 8'h00;
        en_1 = 1'b0; ack_1 = 1'b0; instr_1 = 8'h00;
        smp();
        nxt(); nxt();
        rst_n = 1'b1;
        smp(); chk1("idle_not_busy", busy, 1'b0);
        nxt();

        // MB with zero-wait memory: cycle 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 FETCH
        en = 1'b1; instr_i = 8'b110_00000;
        smp(); chk1("mb_c0_busy", busy, 1'b0); nxt();
        mem_ack = 1'b1;
        smp(); chk1("mb_c1_ir_load", ir_load, 1'b1); chk1("mb_c1_pc_inc", pc_inc, 1'b1); nxt();
        mem_ack = 1'b0;
        smp(); chk1("mb_c2_wr", wr, 1'b0); chk1("mb_c2_busy", busy, 1'b1); nxt();
        smp(); chk1("mb_c3_wr", wr, 1'b1); nxt();
        instr_i = 8'b101_00000; eq_flag = 1'b1; mem_ack = 1'b1;
        smp(); chk1("mb_c4_fetch", mem_req, 1'b1); nxt();
        mem_ack = 1'b0;
        smp(); nxt();

        // JCE taken, JCN not taken / taken
        smp(); chk1("jce_jc", jc, 1'b1); chk1("jce_pc_load", pc_load, 1'b1); nxt();
        fetch(8'b111_00000);
        smp(); chk1("jcn_eq_pc_load", pc_load, 1'b0); chk1("jcn_neq", neq, 1'b1);
        chk1("jcn_no_pc_inc", pc_inc, 1'b0); nxt();
        eq_flag = 1'b0;
        fetch(8'b111_00000);
        smp(); chk1("jcn_ne_pc_load", pc_load, 1'b1); nxt();

        // MR, ack in the fifth EXEC cycle, then one WB cycle
        fetch(8'b011_00000);
        for (int i = 0; i < 4; i++) begin
            smp(); chk1("mr_wait_rm", rm, 1'b1); chk1("mr_wait_wr", wr, 1'b0);
            chk1("mr_wait_addr_sel", addr_sel, 1'b1); nxt();
        end
        mem_ack = 1'b1;
        smp(); chk1("mr_ack_rm", rm, 1'b1); chk1("mr_ack_wr", wr, 1'b0); nxt();
        mem_ack = 1'b0;
        smp(); chk1("mr_wb_wr", wr, 1'b1); chk1("mr_wb_rm", rm, 1'b1); nxt();

        // MFI waits for io_in_valid, writes only on the accepting cycle
        fetch(8'b001_00000);
        for (int i = 0; i < 2; i++) begin
            smp(); chk1("mfi_wait_sin", sin, 1'b1); chk1("mfi_wait_wr", wr, 1'b0); nxt();
        end
        io_in_valid = 1'b1;
        smp(); chk1("mfi_accept_wr", wr, 1'b1); nxt();
        io_in_valid = 1'b0;

        // MW with two wait cycles
        fetch(8'b010_00000);
        smp(); chk1("mw_we", mem_we, 1'b1); nxt();
        smp(); nxt();
        mem_ack = 1'b1;
        smp(); chk1("mw_ack_we", mem_we, 1'b1); nxt();

        // J with en dropped mid-instruction: completes, then parks in IDLE
        fetch(8'b100_00000);
        en = 1'b0;
        smp(); chk1("j_j", j, 1'b1); chk1("j_pc_load", pc_load, 1'b1); nxt();
        mem_ack = 1'b1;
        smp(); chk1("j_then_idle", busy, 1'b0); nxt();
        mem_ack = 1'b0; en = 1'b1;
        smp(); nxt();

        // R held for three cycles of io_out_ready low
        fetch(8'b000_00000);
        for (int i = 0; i < 3; i++) begin
            smp(); chk1("r_wait_sout", sout, 1'b1); nxt();
        end
        io_out_ready = 1'b1;
        smp(); chk1("r_ready_sout", sout, 1'b1); nxt();
        io_out_ready = 1'b0;

        // R aborted by an asynchronous reset pulse mid-wait
        fetch(8'b000_00000);
        smp(); chk1("r2_sout", sout, 1'b1);
        #2 rst_n = 1'b0;
        #1 chkv("async_reset_zero", act0, '0);
        nxt();
        en = 1'b0; rst_n = 1'b1;
        smp(); chk1("restart_idle", busy, 1'b0); nxt();
        en = 1'b1;
        smp(); nxt();

        // MW acked in the same cycle the wait count reaches WAIT_MAX: no timeout
        fetch(8'b010_00000);
        for (int i = 0; i < WAIT_MAX; i++) begin
            smp(); nxt();
        end
        mem_ack = 1'b1;
        smp(); chk1("edge_ack_no_timeout", timeout, 1'b0); nxt();
        mem_ack = 1'b0;
        smp(); chk1("edge_back_fetch", mem_req, 1'b1); chk1("edge_busy", busy, 1'b1); nxt();

        // MW with no ack: 16 waiting cycles, then HALT with timeout
        fetch(8'b010_00000);
        for (int i = 0; i < 16; i++) begin
            smp(); chk1("to_wait_timeout", timeout, 1'b0); chk1("to_wait_mem_req", mem_req, 1'b1); nxt();
        end
        smp(); chk1("to_timeout", timeout, 1'b1); chk1("to_mem_req_drop", mem_req, 1'b0);
        chk1("to_halt_busy", busy, 1'b0); nxt();
        mem_ack = 1'b1;
        smp(); chk1("to_halt_stays", busy, 1'b0); nxt();
        mem_ack = 1'b0;
        rst_n = 1'b0; en = 1'b0;
        #1 chk1("to_reset_clears", timeout, 1'b0);
        smp(); nxt();
        rst_n = 1'b1;

        // 4-bit opcode instance: 1000 is illegal
        en_1 = 1'b1; instr_1 = 8'b1000_0000;
        smp(); nxt();
        ack_1 = 1'b1;
        smp(); chk1("w4_ir_load", ir_load_1, 1'b1); nxt();
        ack_1 = 1'b0;
        smp(); chk1("w4_decode_illegal", illegal_1, 1'b0); chk1("w4_decode_busy", busy_1, 1'b1); nxt();
        for (int i = 0; i < 3; i++) begin
            smp(); chk1("w4_illegal", illegal_1, 1'b1); chk1("w4_halt_busy", busy_1, 1'b0);
            chk1("w4_halt_mem_req", mem_req_1, 1'b0); nxt();
        end
        chk1("w4_no_wr_pc_load", w4_strobe_seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
